// File: rtl/mandel_pkg.sv
// mandel_pkg: shared widths, escape threshold and FSM encoding for the Mandelbrot engine
package mandel_pkg;
  localparam int WIDTH = 32;
  localparam int FRAC = 28;
  localparam int MAX_ITER = 255;
  localparam logic [2*WIDTH:0] ESC_THRESH = (2*WIDTH+1)'(4) << (2*FRAC);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mandel_step.sv
// mandel_step: one combinational z <- z^2 + c step with escape detection on the current z
module mandel_step
  import mandel_pkg::*;
#(
  parameter int W = WIDTH,
  parameter int F = FRAC
) (
  input  logic signed [W-1:0] zr,
  input  logic signed [W-1:0] zi,
  input  logic signed [W-1:0] c_re,
  input  logic signed [W-1:0] c_im,
  output logic signed [W-1:0] zr_next,
  output logic signed [W-1:0] zi_next,
  output logic                escape
);
  localparam logic [2*W:0] ESC = (2*W+1)'(4) << (2*F);
  logic signed [2*W-1:0] p_rr, p_ii, p_ri, d;
  logic signed [2*W:0] mag;
  logic unused_bits;
  assign p_rr = zr * zr;
  assign p_ii = zi * zi;
  assign p_ri = zr * zi;
  assign d = p_rr - p_ii;
  assign mag = $signed({p_rr[2*W-1], p_rr}) + $signed({p_ii[2*W-1], p_ii});
  assign escape = $unsigned(mag) > ESC;
  assign zr_next = d[F+W-1:F] + c_re;
  assign zi_next = p_ri[F+W-2:F-1] + c_im;
  assign unused_bits = ^{d[F-1:0], d[2*W-1:F+W], p_ri[F-2:0], p_ri[2*W-1:F+W-1]};
endmodule

// File: rtl/mandel_iter_engine.sv
// mandel_iter_engine: per-pixel Mandelbrot escape counter with valid/ready on both sides
module mandel_iter_engine
  import mandel_pkg::*;
#(
  parameter int WIDTH = mandel_pkg::WIDTH,
  parameter int FRAC = mandel_pkg::FRAC,
  parameter int MAX_ITER = mandel_pkg::MAX_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] c_re,
  input  logic [WIDTH-1:0] c_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      iteration
);
  state_t state, state_n;
  logic signed [WIDTH-1:0] cr_q, ci_q, zr, zi, zr_next, zi_next;
  logic [31:0] n;
  logic escape, last;
  mandel_step #(.W(WIDTH), .F(FRAC)) u_step (
    .zr(zr),
    .zi(zi),
    .c_re(cr_q),
    .c_im(ci_q),
    .zr_next(zr_next),
    .zi_next(zi_next),
    .escape(escape)
  );
  assign last = (n + 32'd1) == 32'(MAX_ITER);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? ITER : IDLE)
            : state == ITER ? ((escape || last) ? DONE : ITER)
            : state == DONE ? (out_ready ? IDLE : DONE)
            : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cr_q <= '0;
      ci_q <= '0;
      zr <= '0;
      zi <= '0;
      n <= '0;
      iteration <= '0;
    end else if (state == IDLE && in_valid) begin
      cr_q <= c_re;
      ci_q <= c_im;
      zr <= '0;
      zi <= '0;
      n <= '0;
    end else if (state == ITER && escape) begin
      iteration <= n;
    end else if (state == ITER) begin
      zr <= zr_next;
      zi <= zi_next;
      n <= n + 32'd1;
      if (last) iteration <= 32'(MAX_ITER);
    end
  end
endmodule

// File: doc/mandel_iter_engine.md
Name: mandel_iter_engine

Overview:
- Per-pixel Mandelbrot iteration engine. Accepts one complex point c and iterates z <- z^2 + c from z = 0, one iteration per clock.
- Outputs the escape count as a 32-bit iteration value, which is the producer side of the colour ROM's iteration input.
- MAX_ITER (255) means "in set" and maps to black.
- Sits between the pixel-coordinate generator (upstream, valid/ready) and the colour ROM (downstream, valid/ready).

Parameters:
- WIDTH, 32, signed fixed-point width of c and z.
- FRAC, 28, fractional bits (Q4.28: range [-8, 8)).
- MAX_ITER, 255, iteration cap; the result equals MAX_ITER when no escape occurs.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  c_re/c_im valid.
- in_ready  out  1  engine can accept a point.
- c_re  in  WIDTH  real part of c, signed Q4.28; legal range [-2.0, 2.0].
- c_im  in  WIDTH  imaginary part of c, signed Q4.28; legal range [-2.0, 2.0].
- out_valid  out  1  iteration result valid.
- out_ready  in  1  downstream accepts the result.
- iteration  out  32  escape count, 0..MAX_ITER, zero-extended.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - ITER: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- Reset (rst=1 at a clk edge) forces IDLE, z=0, n=0, iteration=0, out_valid=0 and in_ready=1 on the next cycle. This applies from any state, including mid-ITER and DONE with the result unconsumed; that result is discarded.
- IDLE:
  - On in_valid && in_ready, latch c, set z=(0,0) and n=0, and go to ITER.
  - Otherwise hold.
- ITER, each cycle, evaluated on the current z:
  - Squares use full 2*WIDTH-bit signed products: P_rr = zr*zr, P_ii = zi*zi, P_ri = zr*zi.
  - Magnitude: M = P_rr + P_ii in 2*WIDTH+1 bits, compared against ESC = 4 << (2*FRAC).
  - If M > ESC (strictly greater): iteration <= n and go to DONE. z is not updated.
  - Else:
    - zr <= ((P_rr - P_ii) >>> FRAC) + c_re, truncated to WIDTH bits.
    - zi <= (P_ri >>> (FRAC-1)) + c_im, truncated to WIDTH bits.
    - n <= n+1.
    - If n+1 == MAX_ITER, then iteration <= MAX_ITER and go to DONE (no further escape check).
- Shifts are arithmetic (truncate toward -inf). With |c| <= 2 and the pre-update check |z| <= 2, |z_next| <= 6 always fits Q4.28. There is no saturation logic.
- DONE:
  - Hold iteration and out_valid=1 until out_ready.
  - On out_valid && out_ready, go to IDLE; iteration keeps its value, out_valid drops the next cycle.
- The engine never accepts a new point in the same cycle it delivers a result; there is at least one IDLE cycle between jobs.
- Latency:
  - Accept handshake at edge t. out_valid rises after edge t + R + 1, where R is the result.
  - For R = MAX_ITER, ITER lasts MAX_ITER cycles, so out_valid rises after edge t + MAX_ITER + 1.
- Boundary: |z|^2 exactly 4.0 does not escape. For example c=-2 stays at z=2 forever and yields MAX_ITER.
- in_valid while not in IDLE is ignored; upstream must hold its data under valid/ready.

Decomposition:
- Package mandel_pkg holds:
  - WIDTH, FRAC, MAX_ITER defaults.
  - ESC_THRESH constant (4 << 2*FRAC).
  - State encoding: IDLE=2'd0, ITER=2'd1, DONE=2'd2.
  - Helper constant ONE = 1 << FRAC for benches.
- One sub-module, mandel_step: purely combinational.
  - Inputs: zr, zi, c_re, c_im.
  - Outputs: zr_next, zi_next, escape.
  - The engine top holds only the FSM, the n counter, and the registers.

Test Plan:
- c=(0,0) -> iteration=255 with out_valid after 256 cycles; check that in_ready stays low throughout ITER.
- c=(1.0,0) (0x10000000,0) -> z sequence 1, 2, 5; iteration=3; out_valid rises after edge t+4.
- c=(0.5,0) -> z sequence 0.5, 0.75, 1.0625, 1.6289, 3.153; iteration=5. Also c=(2.0,0) -> iteration=2.
- Boundary cases:
  - c=(-2.0,0): |z|^2 == 4 exactly every cycle -> iteration=255.
  - c=(0,1.0): 2-cycle orbit -> iteration=255.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: iteration/out_valid stable and in_ready=0; point accepted only after the handshake plus one IDLE cycle.
- Assert rst during ITER (c=0, n~100) and during DONE. Required: next cycle IDLE, out_valid=0, iteration=0, in_ready=1; a new c=(1.0,0) then yields 3.
